// File: rtl/gray_wptr_ctrl.sv
// rtl/gray_wptr_ctrl.sv - write-side pointer and status controller for a Gray-coded async FIFO
// Publishes a registered Gray write pointer and derives level/full flags from the synchronized read pointer.
module gray_wptr_ctrl #(
  parameter int ADDR_W = 4,
  parameter int AF_TH  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic              clr_ovf,
  input  logic [ADDR_W:0]   rptr_gray_async,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              almost_full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_V    = (ADDR_W+1)'(AF_TH);

  logic [ADDR_W:0] wptr_bin;
  logic [ADDR_W:0] wptr_bin_next;
  logic [ADDR_W:0] rs1;
  logic [ADDR_W:0] rs2;
  logic [ADDR_W:0] rptr_bin;
  logic [ADDR_W:0] lvl_next;

  assign wr_en_out     = wr_req & ~full & rst_n;
  assign wptr_bin_next = wptr_bin + {{ADDR_W{1'b0}}, wr_en_out};
  assign wr_addr       = wptr_bin[ADDR_W-1:0];

  // Gray to binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    rptr_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      rptr_bin[i] = ^(rs2 >> i);
    end
  end

  assign lvl_next = wptr_bin_next - rptr_bin;

  // Plain two-flop synchronizer; nothing may sit between rs1 and rs2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs1 <= '0;
      rs2 <= '0;
    end else begin
      rs1 <= rptr_gray_async;
      rs2 <= rs1;
    end
  end

  // Flags come from the next-state pointer so the filling write blocks the very next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_bin    <= '0;
      wptr_gray   <= '0;
      level       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wptr_bin    <= wptr_bin_next;
      wptr_gray   <= wptr_bin_next ^ (wptr_bin_next >> 1);
      level       <= lvl_next;
      full        <= (lvl_next == DEPTH_V);
      almost_full <= (lvl_next >= AF_V);
      if (wr_req & full) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_wptr_ctrl.sv
// tb/tb_gray_wptr_ctrl.sv - self-checking bench for gray_wptr_ctrl
// Occupancy model built from write counts and delayed read-pointer values, plus directed literal checks.
module tb_gray_wptr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_req;
  logic       clr_ovf;
  logic [4:0] rptr_gray_async;
  logic       wr_en_out;
  logic [3:0] wr_addr;
  logic [4:0] wptr_gray;
  logic [4:0] level;
  logic       full;
  logic       almost_full;
  logic       overflow;

  gray_wptr_ctrl #(.ADDR_W(4), .AF_TH(12)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_req(wr_req),
    .clr_ovf(clr_ovf),
    .rptr_gray_async(rptr_gray_async),
    .wr_en_out(wr_en_out),
    .wr_addr(wr_addr),
    .wptr_gray(wptr_gray),
    .level(level),
    .full(full),
    .almost_full(almost_full),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int rbin = 0;
  int m_wcnt = 0;
  int m_d1 = 0;
  int m_d2 = 0;
  int m_level = 0;
  bit m_full = 0;
  bit m_af = 0;
  bit m_ovf = 0;
  bit m_wrote = 0;
  bit chk_en = 0;
  int pulses = 0;
  bit wrap_seen = 0;
  int addr_log[$];

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model at the edge with the inputs of the finished cycle, then drive the next cycle.
  task automatic step(input bit rstn, input bit req, input bit clr, input int rb);
    bit acc;
    @(posedge clk);
    if (!rst_n) begin
      m_wcnt = 0; m_d1 = 0; m_d2 = 0; m_level = 0;
      m_full = 0; m_af = 0; m_ovf = 0; m_wrote = 0;
      chk_en = 1;
    end else begin
      acc = wr_req && !m_full;
      m_ovf = (wr_req && m_full) ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
      m_wcnt = (m_wcnt + int'(acc)) % 32;
      m_level = (m_wcnt - m_d2 + 32) % 32;
      m_d2 = m_d1;
      m_d1 = rbin;
      m_full = (m_level == 16);
      m_af = (m_level >= 12);
      m_wrote = acc;
    end
    #1;
    rst_n = rstn;
    wr_req = req;
    clr_ovf = clr;
    rbin = rb;
    rptr_gray_async = to_gray(rb);
  endtask

  initial begin : compare
    logic [4:0] prev_gray;
    prev_gray = '0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("wr_en_out", int'(wr_en_out), int'(wr_req && !m_full && rst_n));
        chk("wr_addr", int'(wr_addr), m_wcnt % 16);
        chk("wptr_gray", int'(wptr_gray), int'(to_gray(m_wcnt)));
        chk("level", int'(level), m_level);
        chk("full", int'(full), int'(m_full));
        chk("almost_full", int'(almost_full), int'(m_af));
        chk("overflow", int'(overflow), int'(m_ovf));
        if (m_wrote) begin
          chk("gray_one_bit", $countones(wptr_gray ^ prev_gray), 1);
          if (prev_gray == 5'b10000 && wptr_gray == 5'b00000) wrap_seen = 1;
        end
        if (wr_en_out) begin
          pulses++;
          addr_log.push_back(int'(wr_addr));
        end
      end
      prev_gray = wptr_gray;
    end
  end

  initial begin : stim
    int rb;
    rst_n = 0; wr_req = 1; clr_ovf = 0; rptr_gray_async = '0;

    // Reset with a pending request
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    #1;
    chk("rst_wr_en", int'(wr_en_out), 0);
    chk("rst_wptr_gray", int'(wptr_gray), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_flags", int'({full, almost_full, overflow}), 0);

    // Fill with the read pointer held at 0
    pulses = 0;
    addr_log.delete();
    step(1, 1, 0, 0);
    for (int i = 0; i < 19; i++) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    #1;
    chk("fill_pulses", pulses, 16);
    chk("fill_addr_cnt", addr_log.size(), 16);
    for (int i = 0; i < addr_log.size(); i++) chk("fill_addr_seq", addr_log[i], i);
    chk("fill_gray16", int'(wptr_gray), 5'b11000);
    chk("fill_level", int'(level), 16);
    chk("fill_full", int'(full), 1);
    chk("fill_af", int'(almost_full), 1);
    chk("fill_ovf", int'(overflow), 1);

    // Remote read pointer moves to 4 while full: three edges until flags see it
    step(1, 0, 0, 4);
    step(1, 0, 0, 4);
    #1;
    chk("drain_e1_full", int'(full), 1);
    step(1, 0, 0, 4);
    #1;
    chk("drain_e2_full", int'(full), 1);
    chk("drain_e2_level", int'(level), 16);
    step(1, 0, 0, 4);
    #1;
    chk("drain_e3_full", int'(full), 0);
    chk("drain_e3_level", int'(level), 12);
    chk("drain_e3_af", int'(almost_full), 1);
    step(1, 1, 0, 4);
    #1;
    chk("drain_accept", int'(wr_en_out), 1);
    chk("drain_addr", int'(wr_addr), 0);

    // Wrap: advance the read side, then write through 31 -> 0 with the reader trailing
    for (int k = 5; k <= 17; k++) step(1, 0, 0, k);
    for (int i = 0; i < 16; i++) begin
      rb = rbin;
      if (rb != 30 && ((m_wcnt - rb) & 31) > 2) rb = rb + 1;
      step(1, 1, 0, rb);
    end
    for (int i = 0; i < 40 && rbin != 30; i++) step(1, 0, 0, rbin + 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 30);
    #1;
    chk("wrap_seen", int'(wrap_seen), 1);
    chk("wrap_gray1", int'(wptr_gray), 5'b00001);
    chk("wrap_level", int'(level), 3);
    chk("wrap_full", int'(full), 0);

    // Overflow set-beats-clear, then clear
    step(1, 0, 1, 30);
    for (int i = 0; i < 30; i++) begin
      step(1, 1, 0, 30);
      if (m_full) break;
    end
    #1;
    chk("ovf_full", int'(full), 1);
    step(1, 1, 1, 30);
    step(1, 0, 1, 30);
    #1;
    chk("ovf_set_wins", int'(overflow), 1);
    step(1, 0, 0, 30);
    #1;
    chk("ovf_cleared", int'(overflow), 0);

    // Reset in the middle of a fill
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    #1;
    chk("mid_gray7", int'(wptr_gray), 5'b00100);
    chk("mid_rst_wr_en", int'(wr_en_out), 0);
    step(1, 1, 0, 0);
    #1;
    chk("mid_gray", int'(wptr_gray), 0);
    chk("mid_level", int'(level), 0);
    chk("mid_flags", int'({full, almost_full, overflow}), 0);
    chk("mid_accept", int'(wr_en_out), 1);
    chk("mid_addr", int'(wr_addr), 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
